// File: rtl/rearrng_pkg.sv
// Shared types for the rearrange ping-pong buffer controllers: FSM states, address width, tagged sample.
package rearrng_pkg;

    localparam int DFLT_DATA_WIDTH = 32;
    localparam int DFLT_ROWW       = 3;
    localparam int DFLT_COLW       = 3;

    // Bank select sits above the row/col fields.
    function automatic int addr_width(input int roww, input int colw);
        return 1 + roww + colw;
    endfunction

    localparam int DFLT_ADDRW = addr_width(DFLT_ROWW, DFLT_COLW);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        RELEASE
    } rd_state_t;

    typedef struct packed {
        logic tlast;
        logic tuser;
    } tag_t;

    typedef struct packed {
        logic [DFLT_DATA_WIDTH-1:0] tdata;
        logic                       tlast;
        logic                       tuser;
    } sample_t;

endpackage

// File: rtl/rearrng_skid_fifo.sv
// Two-entry registered FIFO; dout is a register mux, so it carries no combinational path from pop.
// Push is accepted on any cycle, and the caller guarantees no push when full without a pop.
module rearrng_skid_fifo #(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [1:0]   count,
    output logic [W-1:0] dout
);

    logic [W-1:0] mem [0:1];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/rearrng_rd_ctrl.sv
// Read side of the rearrange ping-pong buffer: drains a full bank column-major onto AXI4-Stream.
// Data appears 2 cycles after issue; reads throttle so occupancy plus in-flight never exceeds 2.
module rearrng_rd_ctrl
    import rearrng_pkg::*;
#(
    parameter int DATA_WIDTH = DFLT_DATA_WIDTH,
    parameter int ROWW       = DFLT_ROWW,
    parameter int COLW       = DFLT_COLW,
    parameter int ADDRW      = addr_width(ROWW, COLW)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [1:0]            bank_rdy,
    output logic [1:0]            bank_done,
    output logic                  ram_enb,
    output logic [ADDRW-1:0]      ram_addrb,
    input  logic [DATA_WIDTH-1:0] ram_dob,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser
);

    rd_state_t             state_q;
    rd_state_t             state_d;
    logic                  cur_bank_q;
    logic [ROWW-1:0]       row_q;
    logic [COLW-1:0]       col_q;
    logic                  inflight_q;
    tag_t                  tag_q;
    tag_t                  issue_tag;
    logic [ADDRW-1:0]      addr_q;
    logic [ADDRW-1:0]      cur_addr;
    logic [1:0]            occ;
    logic [DATA_WIDTH+1:0] fifo_dout;
    logic [2:0]            level;
    logic                  pop;
    logic                  issue;
    logic                  last_issue;
    logic                  drained;

    assign m_axis_tvalid = (occ != 2'd0);
    assign pop           = m_axis_tvalid & m_axis_tready;

    // Slots that will be committed after this cycle: buffered + arriving - leaving.
    assign level   = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
    assign drained = !inflight_q && (occ == {1'b0, pop});

    assign cur_addr   = {cur_bank_q, row_q, col_q};
    assign issue_tag  = '{tlast: &row_q, tuser: (row_q == '0) && (col_q == '0)};
    assign last_issue = issue && (&row_q) && (&col_q);

    always_comb begin
        state_d   = state_q;
        issue     = 1'b0;
        bank_done = 2'b00;
        case (state_q)
            IDLE: begin
                if (bank_rdy[cur_bank_q]) begin
                    state_d = READ;
                end
            end
            READ: begin
                issue = (level < 3'd2);
                if (issue && (&row_q) && (&col_q)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drained) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                bank_done = cur_bank_q ? 2'b10 : 2'b01;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cur_bank_q <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            if (issue) begin
                tag_q  <= issue_tag;
                addr_q <= cur_addr;
                if (&row_q) begin
                    row_q <= '0;
                    col_q <= col_q + 1'b1;
                end else begin
                    row_q <= row_q + 1'b1;
                end
            end
            if (state_q == RELEASE) begin
                cur_bank_q <= ~cur_bank_q;
                row_q      <= '0;
                col_q      <= '0;
            end
        end
    end

    assign ram_enb   = issue;
    assign ram_addrb = issue ? cur_addr : addr_q;

    rearrng_skid_fifo #(
        .W (DATA_WIDTH + 2)
    ) u_skid (
        .clk    (clk),
        .resetn (resetn),
        .push   (inflight_q),
        .din    ({ram_dob, tag_q}),
        .pop    (pop),
        .count  (occ),
        .dout   (fifo_dout)
    );

    assign m_axis_tdata = fifo_dout[DATA_WIDTH+1:2];
    assign m_axis_tlast = fifo_dout[1];
    assign m_axis_tuser = fifo_dout[0];

endmodule

// File: tb/tb_rearrng_rd_ctrl.sv
// Randomised bench for rearrng_rd_ctrl with a transposed-order reference model and AXIS checks.
module tb_rearrng_rd_ctrl;
    import rearrng_pkg::*;

    localparam int DW    = DFLT_DATA_WIDTH;
    localparam int AW    = addr_width(DFLT_ROWW, DFLT_COLW);
    localparam int ROWS  = 1 << DFLT_ROWW;
    localparam int COLS  = 1 << DFLT_COLW;
    localparam int BEATS = ROWS * COLS;

    logic          clk = 1'b0;
    logic          resetn;
    logic [1:0]    bank_rdy;
    logic [1:0]    bank_done;
    logic          ram_enb;
    logic [AW-1:0] ram_addrb;
    logic [DW-1:0] ram_dob;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          m_axis_tuser;

    rearrng_rd_ctrl dut (
        .clk           (clk),
        .resetn        (resetn),
        .bank_rdy      (bank_rdy),
        .bank_done     (bank_done),
        .ram_enb       (ram_enb),
        .ram_addrb     (ram_addrb),
        .ram_dob       (ram_dob),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser)
    );

    initial forever #5 clk = ~clk;

    // RAM port B: location holds its own address, one-cycle latency, zero when not enabled.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    initial for (int a = 0; a < (1 << AW); a++) mem[a] = DW'(a);
    always @(posedge clk) ram_dob <= ram_enb ? mem[ram_addrb] : '0;

    int        n_pass, n_chk;
    int        mb, mbank, iss, ibank, nbeat, n_iss, n_hs, enb_cnt, tv_cnt;
    int        tr_mode, cyc;
    logic [1:0] pend;
    logic       prev_stall;
    sample_t    prev;
    logic [DW-1:0] got_d [0:255];
    logic          got_l [0:255];
    logic          got_u [0:255];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, req);
    endtask

    // Word at beat k of a bank: column-major walk, row varies fastest.
    function automatic logic [DW-1:0] exp_word(input int bank, input int k);
        return DW'(bank * BEATS + (k % ROWS) * COLS + k / ROWS);
    endfunction

    task automatic monitor();
        logic hs;
        if (!resetn) begin
            mb = 0; mbank = 0; iss = 0; ibank = 0; nbeat = 0; n_iss = 0; n_hs = 0;
            enb_cnt = 0; tv_cnt = 0; pend = 2'b00; prev_stall = 1'b0; prev = '0;
            return;
        end
        chk("bank_done", bank_done, pend);
        pend = 2'b00;
        if (m_axis_tvalid) tv_cnt++;
        if (prev_stall) begin
            chk("axis_tvalid_held", m_axis_tvalid, 1);
            chk("axis_stable", {m_axis_tdata, m_axis_tlast, m_axis_tuser}, prev);
        end
        if (ram_enb) begin
            chk("ram_addrb", ram_addrb, exp_word(ibank, iss));
            enb_cnt++; n_iss++; iss++;
            if (iss == BEATS) begin iss = 0; ibank ^= 1; end
        end
        hs = m_axis_tvalid && m_axis_tready;
        if (hs) begin
            chk("tdata", m_axis_tdata, exp_word(mbank, mb));
            chk("tlast", m_axis_tlast, (mb % ROWS) == ROWS - 1);
            chk("tuser", m_axis_tuser, mb == 0);
            if (nbeat < 256) begin
                got_d[nbeat] = m_axis_tdata;
                got_l[nbeat] = m_axis_tlast;
                got_u[nbeat] = m_axis_tuser;
            end
            nbeat++; n_hs++; mb++;
            if (mb == BEATS) begin
                pend  = mbank[0] ? 2'b10 : 2'b01;
                mb    = 0;
                mbank ^= 1;
            end
        end
        if (ram_enb) chk("outstanding_le2", (n_iss - n_hs) <= 2, 1);
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev       = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        case (tr_mode)
            0:       m_axis_tready = 1'b0;
            1:       m_axis_tready = 1'b1;
            default: m_axis_tready = ($urandom_range(0, 1) == 1);
        endcase
    endtask

    task automatic do_reset();
        resetn   = 1'b0;
        bank_rdy = 2'b00;
        repeat (3) tick();
        chk("reset_outputs", {m_axis_tvalid, ram_enb, bank_done, m_axis_tlast, m_axis_tuser,
                              m_axis_tdata, ram_addrb}, 0);
        resetn = 1'b1;
    endtask

    task automatic wait_beats(input string nm, input int target, input int budget);
        cyc = 0;
        while (nbeat < target && cyc < budget) begin
            tick();
            cyc++;
        end
        chk(nm, nbeat, target);
    endtask

    initial begin
        n_pass = 0; n_chk = 0; tr_mode = 1;
        m_axis_tready = 1'b0; bank_rdy = 2'b00; resetn = 1'b0;

        // Only the other bank ready: controller must stay idle.
        do_reset();
        bank_rdy = 2'b10;
        repeat (50) tick();
        chk("idle_enb_count", enb_cnt, 0);
        chk("idle_tvalid_count", tv_cnt, 0);

        // Full-rate drain of bank 0, with exact first-to-last latency.
        tr_mode = 1;
        do_reset();
        bank_rdy = 2'b01;
        wait_beats("t1_beats", BEATS, 200);
        chk("t1_cycles", cyc, 67);
        repeat (4) tick();
        chk("t1_no_bank1_reads", enb_cnt, BEATS);
        chk("t1_beat1", got_d[1], 8);
        chk("t1_beat8", got_d[8], 1);
        chk("t1_beat63", got_d[63], 63);
        chk("t1_tlast7", got_l[7], 1);
        chk("t1_tlast6", got_l[6], 0);
        chk("t1_tuser0", got_u[0], 1);
        chk("t1_tuser1", got_u[1], 0);

        // Random backpressure.
        tr_mode = 2;
        do_reset();
        bank_rdy = 2'b01;
        wait_beats("t2_beats", BEATS, 1000);
        repeat (4) tick();
        chk("t2_beat9", got_d[9], 9);

        // Stalled sink right from the first read.
        tr_mode = 0;
        do_reset();
        bank_rdy = 2'b01;
        cyc = 0;
        while (enb_cnt == 0 && cyc < 20) begin tick(); cyc++; end
        chk("t3_first_issue", enb_cnt, 1);
        repeat (100) tick();
        chk("t3_enb_pulses", enb_cnt, 2);
        chk("t3_tvalid", m_axis_tvalid, 1);
        chk("t3_tdata", m_axis_tdata, 0);
        tr_mode = 1;
        wait_beats("t3_beats", BEATS, 200);
        repeat (4) tick();

        // Both banks ready: bank 0 then bank 1.
        tr_mode = 1;
        do_reset();
        bank_rdy = 2'b11;
        wait_beats("t4_beats", 2 * BEATS, 400);
        repeat (4) tick();
        chk("t4_bank1_beat0", got_d[64], 64);
        chk("t4_bank1_beat1", got_d[65], 72);
        chk("t4_bank1_tuser", got_u[64], 1);
        chk("t4_bank1_last", got_d[127], 127);

        // Reset mid-frame, then restart from beat 0 of bank 0.
        tr_mode = 1;
        do_reset();
        bank_rdy = 2'b01;
        wait_beats("t5_pre_beats", 20, 200);
        do_reset();
        bank_rdy = 2'b01;
        wait_beats("t5_beats", BEATS, 200);
        repeat (4) tick();
        chk("t5_beat0", got_d[0], 0);
        chk("t5_tuser0", got_u[0], 1);
        chk("t5_beat20", got_d[20], 34);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
